// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, operation-select codes and default width for the divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam logic DIV_SEL_UNSIGNED = 1'b1;
  localparam logic DIV_SEL_SIGNED = 1'b0;
  localparam int DIV_WIDTH = 32;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration (shift in a dividend bit, compare, subtract).
module div_step import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             din,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] prem_next,
  output logic             qbit
);
  logic [WIDTH:0] t;
  // prem < dvs always holds, so the extra top bit only matters for the compare
  assign t = {prem, din};
  assign qbit = t >= {1'b0, dvs};
  assign prem_next = qbit ? t[WIDTH-1:0] - dvs : t[WIDTH-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 SDIV/UDIV unit, one quotient bit per cycle.
// Optional remainder output enabled by defining DIV_REMAINDER_EN.
module div_unit import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             div_sel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] remainder
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, dvs, prem, prem_n;
  logic qbit, qneg, accept, dvd_neg, dvs_neg;
`ifdef DIV_REMAINDER_EN
  logic rneg;
`endif
  assign ready = state == IDLE;
  assign done = state == DONE;
  assign accept = start && ready;
  assign dvd_neg = div_sel == DIV_SEL_SIGNED && dividend[WIDTH-1];
  assign dvs_neg = div_sel == DIV_SEL_SIGNED && divisor[WIDTH-1];
  always_comb begin
    state_n = state == IDLE ? (accept ? (divisor == '0 ? DONE : CALC) : IDLE) :
              state == CALC ? (cnt == '0 ? FIX : CALC) :
              state == FIX  ? DONE : IDLE;
  end
  div_step #(.WIDTH(WIDTH)) u_step (
    .prem(prem),
    .din(dvd[WIDTH-1]),
    .dvs(dvs),
    .prem_next(prem_n),
    .qbit(qbit)
  );
  // dvd doubles as the quotient shift register: dividend bits leave the top, quotient bits enter the bottom
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      prem <= '0;
      qneg <= 1'b0;
      quotient <= '0;
`ifdef DIV_REMAINDER_EN
      rneg <= 1'b0;
      remainder <= '0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        dvd <= dvd_neg ? -dividend : dividend;
        dvs <= dvs_neg ? -divisor : divisor;
        prem <= '0;
        cnt <= CW'(WIDTH - 1);
        qneg <= dvd_neg ^ dvs_neg;
`ifdef DIV_REMAINDER_EN
        rneg <= dvd_neg;
`endif
        if (divisor == '0) begin
          quotient <= '0;
`ifdef DIV_REMAINDER_EN
          remainder <= dividend;
`endif
        end
      end
      if (state == CALC) begin
        prem <= prem_n;
        dvd <= {dvd[WIDTH-2:0], qbit};
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) begin
        quotient <= qneg ? -dvd : dvd;
`ifdef DIV_REMAINDER_EN
        remainder <= rneg ? -prem : prem;
`endif
      end
    end
  end
endmodule
